mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit. It sits between the EX/MEM register and MEMWB_Reg and drives ReadData_In of MEMWB_Reg.
//  It runs a req/ack handshake with an external data memory, so the memory may have variable latency.
//  Stores: generates byte enables and lane-replicated write data. Loads: extracts the byte or halfword lane and sign- or zero-extends it.
//  Stall_Out drives the hazard unit: MEMWB_Reg WriteEnable = ~Stall_Out, and upstream stages freeze while it is high.
// PARAMETERS
//  TIMEOUT  64  max BUSY cycles waiting for DMem_Ack before abort; 0 = wait forever
//  TO_W     8   width of wait counter; must hold TIMEOUT
// PORTS
//  Clock          in   1   system clock, rising edge
//  Reset          in   1   asynchronous, active-high reset
//  MemRead_In     in   1   load request from EX/MEM
//  MemWrite_In    in   1   store request from EX/MEM
//  MemSize_In     in   2   00 word, 01 half, 10 byte, 11 treated as word
//  MemSigned_In   in   1   1 = sign-extend load (lb/lh), 0 = zero-extend (lbu/lhu)
//  Address_In     in   32  byte address (ALU result)
//  WriteData_In   in   32  store data, right-justified
//  DMem_Req       out  1   memory request, registered
//  DMem_We        out  1   1 = write, registered
//  DMem_Addr      out  32  {Address_In[31:2],2'b00}, registered
//  DMem_ByteEn    out  4   byte lane enables, registered; lane n = bits [8n+7:8n]
//  DMem_WData     out  32  lane-replicated store data, registered
//  DMem_Ack       in   1   memory completion, sampled on Clock rising edge
//  DMem_RData     in   32  read data, valid in the cycle DMem_Ack = 1
//  ReadData_Out   out  32  extended load result -> MEMWB_Reg ReadData_In
//  Stall_Out      out  1   combinational; freeze pipeline
//  Misaligned_Out out  1   combinational; misaligned access this cycle
//  BusError_Out   out  1   registered 1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset (async): state IDLE, wait counter 0, all registered outputs 0.
//   Reset mid-transaction drops DMem_Req immediately; the memory must tolerate an abandoned request.
//  op = MemRead_In | MemWrite_In. MemWrite_In wins if both are high (treated as a store).
//  Little-endian lanes selected by Address_In[1:0].
//  Misaligned: word with addr[1:0]!=0, or half with addr[0]!=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: op & aligned: Stall_Out=1; at the edge, latch Req=1, We, Addr, ByteEn, WData; go BUSY.
//     op & misaligned: Misaligned_Out=1, Stall_Out=0, no request, ReadData_Out unchanged; stay IDLE.
//     no op: Stall_Out=0.
//   BUSY: Stall_Out=1; DMem_* held stable.
//     Edge with DMem_Ack=1: Req<=0, We<=0; on a load, ReadData_Out <= extended data; go DONE.
//     TIMEOUT!=0 and counter reaches TIMEOUT with no Ack: Req<=0, BusError_Out pulses 1 cycle, ReadData_Out<=0, go DONE.
//     Counter clears on entry to BUSY and increments each BUSY cycle.
//   DONE: Stall_Out=0, so MEMWB_Reg captures; unconditionally go IDLE, and the same op is never reissued.
//  Stores leave ReadData_Out unchanged.
//  Minimum latency with Ack in the first BUSY cycle: op in cycle T, DONE in T+2, 3 cycles total.
//  Store lanes:
//   sb: ByteEn = 1<<addr[1:0], WData = {4{WD[7:0]}}
//   sh: ByteEn = addr[1] ? 1100 : 0011, WData = {2{WD[15:0]}}
//   sw: ByteEn = 1111, WData = WD
//  Load extract: byte = RData[8*addr[1:0]+:8]; half = RData[16*addr[1]+:16]; extend per MemSigned_In.
//  Load extract uses the latched address and size, not the live inputs.
//  DMem_Ack outside BUSY is ignored.
// TESTING
//  lbu 0x1003, RData=0x80FF1234, Ack in 1st BUSY -> ByteEn 1000, ReadData_Out=0x00000080; same with lb -> 0xFFFFFF80.
//  sh 0x2002, WD=0x0000ABCD -> DMem_We=1, ByteEn=1100, WData=0xABCDABCD, DMem_Addr=0x2000; ReadData_Out unchanged.
//  lw 0x1001 -> Misaligned_Out=1, Stall_Out=0, DMem_Req stays 0.
//  lw 0x1000, Ack held low for 2 BUSY cycles then high -> Stall_Out high 4 cycles (T..T+3), low in T+4.
//   DMem_Addr is stable throughout.
//  TIMEOUT=4, no Ack -> after 4 BUSY cycles Req falls, BusError_Out=1 for 1 cycle, ReadData_Out=0, Stall_Out drops next cycle.
//  Reset asserted mid-BUSY -> DMem_Req=0 and Stall_Out=0 immediately; a later Ack is ignored; the next op starts cleanly.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store unit. Sits between the EX/MEM register and MEMWB_Reg
//   and talks to an external data memory over a req/ack handshake, so the
//   memory may take any number of cycles to answer.
//   Stores: byte enables plus lane-replicated write data.
//   Loads : selects the byte/halfword lane and sign- or zero-extends it.
//
// Parameters
//   TIMEOUT : max BUSY cycles to wait for DMem_Ack before abort (0 = forever)
//   TO_W    : width of the wait counter, must be able to hold TIMEOUT
//
// Ports
//   Clock, Reset          : rising-edge clock, asynchronous active-high reset
//   MemRead_In/MemWrite_In: load / store request (store wins if both high)
//   MemSize_In            : 00 word, 01 half, 10 byte, 11 word
//   MemSigned_In          : 1 = sign-extend loads
//   Address_In            : byte address
//   WriteData_In          : right-justified store data
//   DMem_Req/We/Addr/ByteEn/WData : registered memory request
//   DMem_Ack, DMem_RData  : memory completion and read data
//   ReadData_Out          : extended load result to MEMWB_Reg
//   Stall_Out             : combinational pipeline freeze
//   Misaligned_Out        : combinational misaligned-access flag
//   BusError_Out          : registered one-cycle pulse on timeout abort
module mem_access_unit #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        MemRead_In,
    input  logic        MemWrite_In,
    input  logic [1:0]  MemSize_In,
    input  logic        MemSigned_In,
    input  logic [31:0] Address_In,
    input  logic [31:0] WriteData_In,
    output logic        DMem_Req,
    output logic        DMem_We,
    output logic [31:0] DMem_Addr,
    output logic [3:0]  DMem_ByteEn,
    output logic [31:0] DMem_WData,
    input  logic        DMem_Ack,
    input  logic [31:0] DMem_RData,
    output logic [31:0] ReadData_Out,
    output logic        Stall_Out,
    output logic        Misaligned_Out,
    output logic        BusError_Out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state_q;
    logic [TO_W-1:0] cnt_q;
    logic           req_q;
    logic           we_q;
    logic [31:0]    addr_q;
    logic [3:0]     be_q;
    logic [31:0]    wdata_q;
    logic [31:0]    rdata_q;
    logic           berr_q;
    // Lane/size/sign of the access in flight; the extract must not depend
    // on whatever the live inputs happen to show during BUSY.
    logic [1:0]     lane_q;
    logic [1:0]     size_q;
    logic           sgn_q;

    logic           op;
    logic           is_word;
    logic           misaligned;
    logic           timeout_hit;
    logic [3:0]     be_d;
    logic [31:0]    wdata_d;
    logic [31:0]    rdata_ext_d;

    // Select the addressed lane of a read word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*lane +: 8];
        h = rdata[16*lane[1] +: 16];
        case (size)
            2'b10:   return sgn ? {{24{b[7]}}, b}  : {24'b0, b};
            2'b01:   return sgn ? {{16{h[15]}}, h} : {16'b0, h};
            default: return rdata;
        endcase
    endfunction

    assign op      = MemRead_In | MemWrite_In;
    assign is_word = (MemSize_In == 2'b00) || (MemSize_In == 2'b11);

    always_comb begin
        misaligned = 1'b0;
        if (is_word)
            misaligned = |Address_In[1:0];
        else if (MemSize_In == 2'b01)
            misaligned = Address_In[0];
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WriteData_In;
        case (MemSize_In)
            2'b10: begin
                be_d    = 4'b0001 << Address_In[1:0];
                wdata_d = {4{WriteData_In[7:0]}};
            end
            2'b01: begin
                be_d    = Address_In[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{WriteData_In[15:0]}};
            end
            default: ;
        endcase
    end

    assign rdata_ext_d = load_extract(DMem_RData, size_q, lane_q, sgn_q);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));

    // Gated by Reset so the hazard unit is released as soon as reset hits,
    // even if the upstream stage has not yet dropped its request.
    assign Stall_Out      = ~Reset & ((state_q == BUSY) ||
                                      ((state_q == IDLE) && op && ~misaligned));
    assign Misaligned_Out = ~Reset & (state_q == IDLE) & op & misaligned;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            berr_q  <= 1'b0;
            lane_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
        end else begin
            berr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op && !misaligned) begin
                        req_q   <= 1'b1;
                        we_q    <= MemWrite_In;
                        addr_q  <= {Address_In[31:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        lane_q  <= Address_In[1:0];
                        size_q  <= MemSize_In;
                        sgn_q   <= MemSigned_In;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (DMem_Ack) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        if (!we_q)
                            rdata_q <= rdata_ext_d;
                        state_q <= DONE;
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        berr_q  <= 1'b1;
                        rdata_q <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                // One cycle with Stall_Out low lets MEMWB_Reg capture; the
                // request that is still on the inputs is not reissued.
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DMem_Req     = req_q;
    assign DMem_We      = we_q;
    assign DMem_Addr    = addr_q;
    assign DMem_ByteEn  = be_q;
    assign DMem_WData   = wdata_q;
    assign ReadData_Out = rdata_q;
    assign BusError_Out = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TB_TIMEOUT = 4;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        MemRead_In, MemWrite_In, MemSigned_In;
    logic [1:0]  MemSize_In;
    logic [31:0] Address_In, WriteData_In;
    logic        DMem_Req, DMem_We, DMem_Ack;
    logic [31:0] DMem_Addr, DMem_WData, DMem_RData, ReadData_Out;
    logic [3:0]  DMem_ByteEn;
    logic        Stall_Out, Misaligned_Out, BusError_Out;

    mem_access_unit #(.TIMEOUT(TB_TIMEOUT), .TO_W(8)) dut (
        .Clock(Clock), .Reset(Reset),
        .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
        .MemSize_In(MemSize_In), .MemSigned_In(MemSigned_In),
        .Address_In(Address_In), .WriteData_In(WriteData_In),
        .DMem_Req(DMem_Req), .DMem_We(DMem_We), .DMem_Addr(DMem_Addr),
        .DMem_ByteEn(DMem_ByteEn), .DMem_WData(DMem_WData),
        .DMem_Ack(DMem_Ack), .DMem_RData(DMem_RData),
        .ReadData_Out(ReadData_Out), .Stall_Out(Stall_Out),
        .Misaligned_Out(Misaligned_Out), .BusError_Out(BusError_Out)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          delay;   // BUSY cycles with Ack low before Ack
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdo;
        logic        keep;    // ReadData_Out must stay at its previous value
        logic [31:0] rdo;
        logic        berr;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rd = 32'h0;
    vec_t        tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: derives the expected request and result directly
    // from the access rules with plain arithmetic.
    function automatic vec_t model(input logic rd, input logic wr, input logic [1:0] size,
                                   input logic sgn, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rdata,
                                   input int delay);
        vec_t        v;
        int unsigned a;
        logic [31:0] val;
        a = 32'(addr[1:0]);
        v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wd = wd; v.rdata = rdata; v.delay = delay;
        if (size == 2'b10) begin
            v.mis = 1'b0;
            v.be  = 4'(1 << a);
            v.wdo = (wd & 32'hFF) * 32'h01010101;
            val   = (rdata >> (8 * a)) & 32'hFF;
            if (sgn && val >= 32'd128) val = val - 32'd256;
        end else if (size == 2'b01) begin
            v.mis = (a % 2) != 0;
            v.be  = (a >= 2) ? 4'b1100 : 4'b0011;
            v.wdo = (wd & 32'hFFFF) * 32'h00010001;
            val   = (rdata >> (16 * (a / 2))) & 32'hFFFF;
            if (sgn && val >= 32'd32768) val = val - 32'd65536;
        end else begin
            v.mis = (a != 0);
            v.be  = 4'b1111;
            v.wdo = wd;
            val   = rdata;
        end
        v.berr = (delay >= TB_TIMEOUT);
        v.keep = wr && !v.berr;
        v.rdo  = v.berr ? 32'h0 : (wr ? 32'h0 : val);
        return v;
    endfunction

    // Called and returns at 1 time unit after a rising edge, unit in IDLE.
    task automatic run_vec(input vec_t v);
        logic [31:0] exp_addr;
        exp_addr = {v.addr[31:2], 2'b00};
        MemRead_In = v.rd; MemWrite_In = v.wr; MemSize_In = v.size;
        MemSigned_In = v.sgn; Address_In = v.addr; WriteData_In = v.wd;
        DMem_Ack = 1'b0; DMem_RData = $urandom;
        #1;
        chkb("issue_misaligned", Misaligned_Out, v.mis);
        chkb("issue_stall", Stall_Out, !v.mis);
        if (v.mis) begin
            @(posedge Clock); #1;
            chkb("mis_no_req", DMem_Req, 1'b0);
            chk("mis_rdata_kept", ReadData_Out, last_rd);
            MemRead_In = 1'b0; MemWrite_In = 1'b0;
            return;
        end
        @(posedge Clock); #1;
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            DMem_Ack   = (k == v.delay);
            DMem_RData = (k == v.delay) ? v.rdata : $urandom;
            // Live inputs wander during BUSY; the unit must use latched values.
            Address_In   = $urandom;
            MemSize_In   = 2'($urandom_range(0, 3));
            MemSigned_In = 1'($urandom_range(0, 1));
            WriteData_In = $urandom;
            #1;
            chkb("busy_req", DMem_Req, 1'b1);
            chkb("busy_stall", Stall_Out, 1'b1);
            chk("busy_addr", DMem_Addr, exp_addr);
            if (k == 0) begin
                chkb("busy_we", DMem_We, v.wr);
                chk("busy_byteen", 32'(DMem_ByteEn), 32'(v.be));
                chk("busy_wdata", DMem_WData, v.wdo);
                chkb("busy_buserr", BusError_Out, 1'b0);
            end
            @(posedge Clock); #1;
            if (k == v.delay) break;
        end
        DMem_Ack = 1'b0; DMem_RData = $urandom;
        Address_In = v.addr; MemSize_In = v.size; MemSigned_In = v.sgn; WriteData_In = v.wd;
        #1;
        chkb("done_req", DMem_Req, 1'b0);
        chkb("done_we", DMem_We, 1'b0);
        chkb("done_stall", Stall_Out, 1'b0);
        chkb("done_buserr", BusError_Out, v.berr);
        chk("done_rdata", ReadData_Out, v.keep ? last_rd : v.rdo);
        if (!v.keep) last_rd = v.rdo;
        MemRead_In = 1'b0; MemWrite_In = 1'b0;
        @(posedge Clock); #1;
        chkb("idle_req", DMem_Req, 1'b0);
        chkb("idle_stall", Stall_Out, 1'b0);
        chkb("idle_buserr", BusError_Out, 1'b0);
        chk("idle_rdata", ReadData_Out, last_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        //          rd    wr    size  sgn   addr        wd            rdata         dly mis   be       wdo           keep  rdo           berr
        tbl[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h1003, 32'h0,        32'h80FF1234, 0, 1'b0, 4'b1000, 32'h0,        1'b0, 32'h00000080, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h1003, 32'h0,        32'h80FF1234, 0, 1'b0, 4'b1000, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000ABCD, 32'h55555555, 0, 1'b0, 4'b1100, 32'hABCDABCD, 1'b1, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h1001, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        1'b1, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0,        32'hDEADBEEF, 2, 1'b0, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0,        32'h12345678, 4, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[6]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h1002, 32'h0,        32'h80017FFF, 0, 1'b0, 4'b1100, 32'h0,        1'b0, 32'hFFFF8001, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h1000, 32'h0,        32'h80017FFF, 1, 1'b0, 4'b0011, 32'h0,        1'b0, 32'h00007FFF, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h3001, 32'h12345678, 32'h0,        0, 1'b0, 4'b0010, 32'h78787878, 1'b1, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 1'b1, 2'b11, 1'b0, 32'h4000, 32'hCAFEF00D, 32'h0,        1, 1'b0, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0,        1'b0};
        tbl[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h2001, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        1'b1, 32'h0,        1'b0};
        tbl[11] = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h1001, 32'h0,        32'h00007F00, 3, 1'b0, 4'b0010, 32'h0,        1'b0, 32'h0000007F, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h5000, 32'h1,        32'h0,        5, 1'b0, 4'b1111, 32'h1,        1'b0, 32'h0,        1'b1};

        Reset = 1'b1;
        MemRead_In = 1'b0; MemWrite_In = 1'b0; MemSize_In = 2'b00; MemSigned_In = 1'b0;
        Address_In = 32'h0; WriteData_In = 32'h0; DMem_Ack = 1'b0; DMem_RData = 32'h0;
        repeat (2) @(posedge Clock);
        #1;
        chkb("rst_req", DMem_Req, 1'b0);
        chkb("rst_we", DMem_We, 1'b0);
        chk("rst_addr", DMem_Addr, 32'h0);
        chk("rst_byteen", 32'(DMem_ByteEn), 32'h0);
        chk("rst_wdata", DMem_WData, 32'h0);
        chk("rst_rdata", ReadData_Out, 32'h0);
        chkb("rst_buserr", BusError_Out, 1'b0);
        chkb("rst_stall", Stall_Out, 1'b0);
        Reset = 1'b0;
        @(posedge Clock); #1;

        for (int i = 0; i < 13; i++) run_vec(tbl[i]);

        // Reset in the middle of a BUSY wait.
        MemRead_In = 1'b1; MemSize_In = 2'b00; Address_In = 32'h1000;
        @(posedge Clock); #1;
        chkb("pre_rst_req", DMem_Req, 1'b1);
        #1;
        Reset = 1'b1; MemRead_In = 1'b0;
        #1;
        chkb("midrst_req", DMem_Req, 1'b0);
        chkb("midrst_stall", Stall_Out, 1'b0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        DMem_Ack = 1'b1; DMem_RData = 32'hA5A5A5A5;
        @(posedge Clock); #1;
        chkb("late_ack_req", DMem_Req, 1'b0);
        chkb("late_ack_stall", Stall_Out, 1'b0);
        chk("late_ack_rdata", ReadData_Out, 32'h0);
        DMem_Ack = 1'b0;
        last_rd = 32'h0;
        run_vec(tbl[0]);

        // Randomised accesses against the reference model.
        for (int i = 0; i < 80; i++) begin
            logic        rd, wr;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) begin
                DMem_Ack = 1'b1; DMem_RData = $urandom;
                @(posedge Clock); #1;
                chkb("rnd_idle_req", DMem_Req, 1'b0);
                chkb("rnd_idle_stall", Stall_Out, 1'b0);
                chk("rnd_idle_rdata", ReadData_Out, last_rd);
                DMem_Ack = 1'b0;
            end else begin
                run_vec(model(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                              $urandom, $urandom, $urandom, int'($urandom_range(0, 5))));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
